game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/vga_pkg.sv | 22 ++
 rtl/score_counter.sv | 27 ++
 rtl/game_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared display geometry, game constants and the game-state encoding used by
// the sequencer, ball datapath and renderers.
package vga_pkg;

    localparam int unsigned HOR_PIXELS        = 640;
    localparam int unsigned BALL_SIZE         = 16;
    localparam int unsigned EDGE_MARGIN       = 8;
    localparam int unsigned WIN_SCORE_DEFAULT = 7;
    localparam int unsigned X_W               = 11;

    typedef enum logic [1:0] {
        StStart    = 2'b00,
        StPlay     = 2'b01,
        StServe    = 2'b10,
        StGameOver = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/score_counter.sv
// 4-bit score register with synchronous clear and an increment that saturates
// at MAX_VAL.
module score_counter #(
    parameter int unsigned MAX_VAL = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_count
);

    localparam logic [3:0] MaxCount = 4'(MAX_VAL);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= 4'd0;
        end else if (i_inc && (r_count != MaxCount)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/game_sequencer.sv
// Match-level FSM for the pong game: start/serve/play/game-over sequencing,
// edge-of-field scoring, per-player score counters and winner flag.
module game_sequencer
    import vga_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = WIN_SCORE_DEFAULT,
    parameter int unsigned SERVE_TICKS = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timing_tick,
    input  logic             start_btn,
    input  logic [X_W-1:0]   x_ball,
    output state_t           state,
    output logic [3:0]       score_left,
    output logic [3:0]       score_right,
    output logic             point_left,
    output logic             point_right,
    output logic [1:0]       winner
);

    localparam logic [X_W-1:0] LeftLimit  = X_W'(EDGE_MARGIN);
    localparam logic [X_W-1:0] RightLimit = X_W'(HOR_PIXELS - BALL_SIZE - EDGE_MARGIN);
    localparam logic [7:0]     ServeLast  = 8'(SERVE_TICKS - 1);
    localparam logic [4:0]     WinVal     = 5'(WIN_SCORE);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_start_prev;
    logic       r_start_blocked;
    logic [7:0] r_serve_cnt;
    logic [7:0] w_serve_cnt_next;
    logic       r_point_left;
    logic       r_point_right;
    logic [1:0] r_winner;
    logic [1:0] w_winner_next;

    logic       w_start_pulse;
    logic       w_hit_left;
    logic       w_hit_right;
    logic       w_score_left;
    logic       w_score_right;
    logic       w_left_final;
    logic       w_right_final;
    logic       w_clear;
    logic       w_serve_done;

    // A button already held during reset stays blocked until it is seen released.
    assign w_start_pulse = start_btn & ~r_start_prev & ~r_start_blocked;

    assign w_hit_left    = (x_ball <= LeftLimit);
    assign w_hit_right   = (x_ball >= RightLimit);
    assign w_left_final  = ({1'b0, score_left} + 5'd1) == WinVal;
    assign w_right_final = ({1'b0, score_right} + 5'd1) == WinVal;
    assign w_serve_done  = timing_tick && (r_serve_cnt == ServeLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StStart;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StStart: begin
                if (w_start_pulse) w_state_next = StServe;
            end
            StServe: begin
                if (w_serve_done) w_state_next = StPlay;
            end
            StPlay: begin
                if (w_score_right) begin
                    w_state_next = w_right_final ? StGameOver : StServe;
                end else if (w_score_left) begin
                    w_state_next = w_left_final ? StGameOver : StServe;
                end
            end
            StGameOver: begin
                if (w_start_pulse) w_state_next = StStart;
            end
        endcase
    end

    always_comb begin
        // Left-edge hit wins when both edges are flagged in the same cycle.
        w_score_right    = (r_state == StPlay) && w_hit_left;
        w_score_left     = (r_state == StPlay) && w_hit_right && !w_hit_left;
        w_clear          = (r_state == StStart) && w_start_pulse;
        w_serve_cnt_next = r_serve_cnt;
        w_winner_next    = r_winner;

        if (w_clear) begin
            w_serve_cnt_next = 8'd0;
            w_winner_next    = WIN_NONE;
        end else if ((r_state == StServe) && timing_tick) begin
            w_serve_cnt_next = w_serve_done ? 8'd0 : r_serve_cnt + 8'd1;
        end else if (w_score_right) begin
            w_serve_cnt_next = 8'd0;
            if (w_right_final) w_winner_next = WIN_RIGHT;
        end else if (w_score_left) begin
            w_serve_cnt_next = 8'd0;
            if (w_left_final) w_winner_next = WIN_LEFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_prev    <= 1'b0;
            r_start_blocked <= start_btn;
            r_serve_cnt     <= 8'd0;
            r_point_left    <= 1'b0;
            r_point_right   <= 1'b0;
            r_winner        <= WIN_NONE;
        end else begin
            r_start_prev    <= start_btn;
            r_start_blocked <= r_start_blocked & start_btn;
            r_serve_cnt     <= w_serve_cnt_next;
            r_point_left    <= w_score_left;
            r_point_right   <= w_score_right;
            r_winner        <= w_winner_next;
        end
    end

    score_counter #(
        .MAX_VAL (WIN_SCORE)
    ) u_score_left (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clear),
        .i_inc   (w_score_left),
        .o_count (score_left)
    );

    score_counter #(
        .MAX_VAL (WIN_SCORE)
    ) u_score_right (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clear),
        .i_inc   (w_score_right),
        .o_count (score_right)
    );

    assign state       = r_state;
    assign point_left  = r_point_left;
    assign point_right = r_point_right;
    assign winner      = r_winner;

endmodule
